// File: rtl/decoder_irq_ctrl.sv
// Interrupt controller with pending/enable/edge registers and a 16-bit Avalon-MM slave.
// Define DECODER_IRQ_CTRL_SYNC_EN to add a 2-flop synchronizer on irq_in.
module decoder_irq_ctrl #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               chipselect,
  input  logic [2:0]         address,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out,
  output logic [3:0]         irq_id
);

  // Bits at index NUM_IRQ and above are held at zero in every register.
  localparam logic [15:0] IMPL_MASK = 16'((32'd1 << NUM_IRQ) - 32'd1);

  logic [NUM_IRQ-1:0] irq_src;
  logic [15:0]        src16;
  logic [15:0]        irq_prev;
  logic [15:0]        pending;
  logic [15:0]        enable;
  logic [15:0]        edge_mode;
  logic [15:0]        irq_count;
  logic [15:0]        act;
  logic [15:0]        set_vec;
  logic [15:0]        clr_vec;
  logic [15:0]        rd_mux;
  logic               any_act;
  logic               count_inc;
  logic               wr_any;
  logic               wr_pend;
  logic               wr_enable;
  logic               wr_edge;
  logic               wr_count;
  logic               wr_swtrig;

  function automatic logic [3:0] first_set(input logic [15:0] v);
    logic [3:0] f;
    f = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) f = 4'(i);
    end
    return f;
  endfunction

`ifdef DECODER_IRQ_CTRL_SYNC_EN
  logic [NUM_IRQ-1:0] sync_p0;
  logic [NUM_IRQ-1:0] sync_p1;

  // Synchronizer stages: irq_in -> sync_p0 -> sync_p1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= irq_in;
      sync_p1 <= sync_p0;
    end
  end

  assign irq_src = sync_p1;
`else
  assign irq_src = irq_in;
`endif

  assign src16     = 16'(irq_src);
  assign wr_any    = chipselect & ~write_n;
  assign wr_pend   = wr_any & (address == 3'd1);
  assign wr_enable = wr_any & (address == 3'd2);
  assign wr_edge   = wr_any & (address == 3'd3);
  assign wr_count  = wr_any & (address == 3'd5);
  assign wr_swtrig = wr_any & (address == 3'd6);

  assign set_vec = ((src16 & ~irq_prev & edge_mode) |
                    (src16 & ~edge_mode) |
                    (wr_swtrig ? writedata : 16'h0000)) & IMPL_MASK;
  assign clr_vec = wr_pend ? writedata : 16'h0000;

  assign act       = pending & enable;
  assign any_act   = |act;
  assign count_inc = any_act & ~irq_out;

  always_comb begin
    rd_mux = 16'h0000;
    case (address)
      3'd0:    rd_mux = src16;
      3'd1:    rd_mux = pending;
      3'd2:    rd_mux = enable;
      3'd3:    rd_mux = edge_mode;
      3'd4:    rd_mux = {any_act, 11'd0, irq_id};
      3'd5:    rd_mux = irq_count;
      default: rd_mux = 16'h0000;
    endcase
  end

  // Pending/config registers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_prev  <= 16'h0000;
      pending   <= 16'h0000;
      enable    <= 16'h0000;
      edge_mode <= 16'h0000;
      irq_out   <= 1'b0;
      irq_id    <= 4'd0;
      readdata  <= 16'h0000;
    end else begin
      irq_prev <= src16;
      pending  <= set_vec | (pending & ~clr_vec);
      if (wr_enable) enable <= writedata & IMPL_MASK;
      if (wr_edge)   edge_mode <= writedata & IMPL_MASK;
      irq_out  <= any_act;
      irq_id   <= first_set(act);
      readdata <= rd_mux;
    end
  end

  // Assertion counter: a write clears it and beats a same-cycle increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_count <= 16'h0000;
    end else if (wr_count) begin
      irq_count <= 16'h0000;
    end else if (count_inc && irq_count != 16'hFFFF) begin
      irq_count <= irq_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_decoder_irq_ctrl.sv
// Scoreboard testbench for decoder_irq_ctrl (default build, NUM_IRQ = 8).
module tb_decoder_irq_ctrl;

  logic        clk;
  logic        reset_n;
  logic        chipselect;
  logic [2:0]  address;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [7:0]  irq_in;
  logic        irq_out;
  logic [3:0]  irq_id;

  decoder_irq_ctrl #(.NUM_IRQ(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq_out    (irq_out),
    .irq_id     (irq_id)
  );

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] exp;
    string       name;
  } chk_t;

  chk_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   end_req = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every entry that falls due at this negedge
  always @(negedge clk) begin
    logic [15:0] act_v;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due <= cyc) begin
        act_v = (sb_q[i].kind == 0) ? readdata : {11'd0, irq_out, irq_id};
        n_checks++;
        if (sb_q[i].due < cyc || act_v !== sb_q[i].exp) begin
          n_errors++;
          $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                   sb_q[i].name, act_v, sb_q[i].exp, cyc, sb_q[i].due);
        end
        sb_q.delete(i);
      end
    end
    if (end_req && sb_q.size() > 0) begin
      n_errors += sb_q.size();
      $display("FAIL drain: %0d expectations never checked, required 0", sb_q.size());
      sb_q.delete();
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(int due, int kind, logic [15:0] exp, string name);
    chk_t c;
    c.due  = due;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    sb_q.push_back(c);
  endfunction

  function automatic void exp_irq(int ofs, logic o, logic [3:0] id, string name);
    push(cyc + ofs, 1, {11'd0, o, id}, name);
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 16'h0000;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [15:0] exp, input string name);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    push(cyc + 1, 0, exp, name);
    tick();
    chipselect = 1'b0;
  endtask

  // Toggle irq_in[0] while a PENDING W1C is held on the bus: one irq_out rise per pulse
  task automatic pulses(input int n);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 3'd1;
    writedata  = 16'h0001;
    for (int p = 0; p < n; p++) begin
      irq_in = 8'h01;
      tick();
      irq_in = 8'h00;
      tick();
    end
    tick();
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 16'h0000;
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    address    = 3'd0;
    write_n    = 1'b1;
    writedata  = 16'h0000;
    irq_in     = 8'h00;

    // Reset state
    tick();
    irq_in = 8'h01;
    exp_irq(0, 1'b0, 4'd0, "rst_during0");
    exp_irq(1, 1'b0, 4'd0, "rst_during1");
    tick();
    tick();
    irq_in  = 8'h00;
    reset_n = 1'b1;
    exp_irq(0, 1'b0, 4'd0, "rst_after");
    for (int a = 0; a < 8; a++) bus_read(3'(a), 16'h0000, $sformatf("rst_reg%0d", a));

    // Level-mode pulse on source 0
    bus_write(3'd2, 16'h0001);
    irq_in = 8'h01;
    exp_irq(1, 1'b0, 4'd0, "t2_lat1");
    exp_irq(2, 1'b1, 4'd0, "t2_lat2");
    tick();
    irq_in = 8'h00;
    bus_read(3'd1, 16'h0001, "t2_pend");
    bus_write(3'd1, 16'h0001);
    exp_irq(0, 1'b1, 4'd0, "t2_w1c_lat1");
    exp_irq(1, 1'b0, 4'd0, "t2_w1c_lat2");
    bus_read(3'd5, 16'h0001, "t2_count");

    // Edge source 2 held high, level source 1 joins later
    bus_write(3'd3, 16'h0004);
    bus_write(3'd2, 16'h0006);
    irq_in = 8'h04;
    exp_irq(2, 1'b1, 4'd2, "t3_id2");
    repeat (5) tick();
    irq_in = 8'h06;
    exp_irq(1, 1'b1, 4'd2, "t3_pre");
    exp_irq(2, 1'b1, 4'd1, "t3_id1_lowest");
    tick();
    bus_read(3'd1, 16'h0006, "t3_pend_both");
    bus_write(3'd1, 16'h0004);
    bus_read(3'd1, 16'h0002, "t3_w1c_edge");
    tick();
    irq_in = 8'h02;
    exp_irq(0, 1'b1, 4'd1, "t3_id1_hold");
    bus_read(3'd1, 16'h0002, "t3_stay_clr");
    irq_in = 8'h00;
    tick();
    bus_write(3'd1, 16'h00FF);
    exp_irq(1, 1'b0, 4'd0, "t3_clear");
    bus_write(3'd3, 16'h0000);
    bus_read(3'd5, 16'h0002, "t3_count");

    // Level source 3 re-pends after W1C
    bus_write(3'd2, 16'h0008);
    irq_in = 8'h08;
    exp_irq(2, 1'b1, 4'd3, "t4_on");
    tick();
    tick();
    bus_write(3'd1, 16'h0008);
    exp_irq(0, 1'b1, 4'd3, "t4_hold0");
    exp_irq(1, 1'b1, 4'd3, "t4_hold1");
    bus_read(3'd1, 16'h0008, "t4_repend");
    irq_in = 8'h00;
    tick();
    bus_write(3'd1, 16'h0008);
    exp_irq(1, 1'b0, 4'd0, "t4_off");

    // Software trigger, masking and unimplemented bits
    bus_write(3'd2, 16'h0000);
    bus_write(3'd6, 16'h0080);
    exp_irq(1, 1'b0, 4'd0, "t5_masked");
    bus_write(3'd6, 16'hFF00);
    bus_read(3'd1, 16'h0080, "t5_pend");
    bus_read(3'd6, 16'h0000, "t5_swtrig_rd0");
    bus_write(3'd2, 16'h0080);
    exp_irq(1, 1'b1, 4'd7, "t5_id7");
    tick();
    bus_read(3'd4, 16'h8007, "t5_active");
    bus_write(3'd2, 16'hFFFF);
    bus_read(3'd2, 16'h00FF, "t5_enable_mask");
    irq_in = 8'hA5;
    bus_read(3'd0, 16'h00A5, "t5_status");
    irq_in = 8'h00;
    tick();
    bus_write(3'd1, 16'hFFFF);
    bus_write(3'd2, 16'h0001);
    bus_read(3'd5, 16'h0004, "t5_count");

    // COUNT: increments, clear beating increment, saturation
    pulses(10);
    bus_read(3'd5, 16'h000E, "t6_count14");
    irq_in = 8'h01;
    tick();
    bus_write(3'd5, 16'h0000);
    irq_in = 8'h00;
    exp_irq(0, 1'b1, 4'd0, "t6_rise_at_clr");
    bus_read(3'd5, 16'h0000, "t6_clr_wins");
    bus_write(3'd1, 16'h0001);
    tick();
    tick();
    force dut.irq_count = 16'hFFFD;
    #1;
    release dut.irq_count;
    pulses(3);
    bus_read(3'd5, 16'hFFFF, "t6_sat");
    pulses(1);
    bus_read(3'd5, 16'hFFFF, "t6_sat_hold");
    bus_write(3'd5, 16'h1234);
    bus_read(3'd5, 16'h0000, "t6_any_write_clr");

    // Asynchronous reset mid-operation
    irq_in = 8'h01;
    tick();
    exp_irq(1, 1'b1, 4'd0, "t7_pre");
    tick();
    tick();
    reset_n = 1'b0;
    exp_irq(0, 1'b0, 4'd0, "t7_async_drop");
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    bus_read(3'd1, 16'h0001, "t7_repend");
    exp_irq(0, 1'b0, 4'd0, "t7_masked_after_rst");
    bus_read(3'd2, 16'h0000, "t7_enable_rst");
    bus_read(3'd3, 16'h0000, "t7_edge_rst");
    bus_read(3'd5, 16'h0000, "t7_count_rst");
    irq_in = 8'h00;

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) tick();
    end_req = 1'b1;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
